// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Writer-side hazard tracker. Records the destination of every
//                issued register-writing instruction through EX/MEM/WB and
//                checks the decode instruction's rs/rt against them. Drives
//                the per-operand forwarding selects and the one-cycle
//                load-use stall.
//  Option      : HAZARD_STATS_EN adds stall_count[31:0], a wrapping count of
//                stall cycles that ignores flushed cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter logic [4:0] ALU_OP  = 5'b00000,
  parameter logic [4:0] ADDI_OP = 5'b00101,
  parameter logic [4:0] LW_OP   = 5'b01000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_opcode,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        flush,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_count,
`endif
  output logic        stall,
  output logic [1:0]  fwd_rs,
  output logic [1:0]  fwd_rt
);

  // One pipeline slot: valid writer, load flag, destination register.
  typedef struct packed {
    logic       v;
    logic       ld;
    logic [4:0] rd;
  } slot_t;

  localparam slot_t BUBBLE = '{v: 1'b0, ld: 1'b0, rd: 5'd0};

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  slot_t ex_q,  ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;

  slot_t decode_entry;

  // Forwarding select for one source: youngest producer wins, but a load
  // still in EX has no data yet, so it is skipped (the stall covers it).
  function automatic logic [1:0] pick_fwd(input logic  valid,
                                          input logic [4:0] src,
                                          input slot_t ex,
                                          input slot_t mem,
                                          input slot_t wb);
    logic [1:0] sel;
    sel = SEL_RF;
    if (valid && (src != 5'd0)) begin
      if (ex.v && (ex.rd == src) && !ex.ld) begin
        sel = SEL_EX;
      end else if (mem.v && (mem.rd == src)) begin
        sel = SEL_MEM;
      end else if (wb.v && (wb.rd == src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  // Classify the decode instruction: only writers to a non-zero rd create an entry.
  always_comb begin
    decode_entry    = BUBBLE;
    decode_entry.rd = issue_rd;
    decode_entry.ld = (issue_opcode == LW_OP);
    decode_entry.v  = ((issue_opcode == ALU_OP) || (issue_opcode == ADDI_OP) ||
                       (issue_opcode == LW_OP)) && (issue_rd != 5'd0);
  end

  // Load-use stall and forwarding selects for the instruction in decode.
  always_comb begin
    stall  = issue_valid && ex_q.v && ex_q.ld &&
             ((ex_q.rd == issue_rs) || (ex_q.rd == issue_rt));
    fwd_rs = pick_fwd(issue_valid, issue_rs, ex_q, mem_q, wb_q);
    fwd_rt = pick_fwd(issue_valid, issue_rt, ex_q, mem_q, wb_q);
  end

  // Next slot contents: shift down, flush kills EX and the entry moving into MEM.
  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;
    ex_d  = BUBBLE;
    if (flush) begin
      mem_d = BUBBLE;
    end else if (issue_valid && !stall) begin
      ex_d = decode_entry;
    end
  end

  // Slot registers; reset discards every in-flight entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Count stall cycles that were not flushed; wraps naturally at 2^32.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !flush) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  // Statistics register.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. Directed scenarios
//                followed by random instruction streams, all compared against
//                a history-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam logic [4:0] ALU_OP  = 5'b00000;
  localparam logic [4:0] ADDI_OP = 5'b00101;
  localparam logic [4:0] LW_OP   = 5'b01000;
  localparam logic [4:0] SW_OP   = 5'b01011;
  localparam logic [4:0] BEQ_OP  = 5'b00100;
  localparam logic [4:0] J_OP    = 5'b00010;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_opcode, issue_rd, issue_rs, issue_rt;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_rs, fwd_rt;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_opcode(issue_opcode),
    .issue_rd    (issue_rd),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .flush       (flush),
`ifdef HAZARD_STATS_EN
    .stall_count (stall_count),
`endif
    .stall       (stall),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // hist[0] is the instruction that entered the pipe most recently (EX),
  // hist[1] the one before (MEM), hist[2] the one before that (WB).
  typedef struct {
    bit       v;
    bit       ld;
    bit [4:0] rd;
  } ent_t;

  ent_t        hist[$];
  int unsigned m_count;

  function automatic ent_t bubble();
    ent_t e;
    e.v = 0; e.ld = 0; e.rd = 0;
    return e;
  endfunction

  function automatic bit is_writer(logic [4:0] op);
    return (op == ALU_OP) || (op == ADDI_OP) || (op == LW_OP);
  endfunction

  function automatic bit m_stall();
    if (!issue_valid) return 0;
    return hist[0].v && hist[0].ld &&
           (hist[0].rd == issue_rs || hist[0].rd == issue_rt);
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] src);
    if (!issue_valid || src == 0) return 2'b00;
    if (hist[0].v && hist[0].rd == src && !hist[0].ld) return 2'b01;
    if (hist[1].v && hist[1].rd == src) return 2'b10;
    if (hist[2].v && hist[2].rd == src) return 2'b11;
    return 2'b00;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) hist.push_back(bubble());
    m_count = 0;
  end

  // Advance the model history at every clock edge from the current inputs.
  always @(posedge clock) begin
    ent_t nw;
    bit   st;
    st = m_stall();
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] = bubble();
      m_count = 0;
    end else begin
      if (st && !flush) m_count = m_count + 1;
      nw = bubble();
      if (issue_valid && !st && !flush && is_writer(issue_opcode) && issue_rd != 0) begin
        nw.v  = 1;
        nw.ld = (issue_opcode == LW_OP);
        nw.rd = issue_rd;
      end
      if (flush) hist[0] = bubble();
      hist.push_front(nw);
      void'(hist.pop_back());
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one decode cycle at the falling edge, then compare against the model.
  task automatic apply(input logic v, input logic [4:0] op, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl, input logic rst);
    @(negedge clock);
    issue_valid  = v;
    issue_opcode = op;
    issue_rd     = rd;
    issue_rs     = rs;
    issue_rt     = rt;
    flush        = fl;
    reset        = rst;
    #1;
    check("stall",  {31'd0, stall},  {31'd0, m_stall()});
    check("fwd_rs", {30'd0, fwd_rs}, {30'd0, m_fwd(issue_rs)});
    check("fwd_rt", {30'd0, fwd_rt}, {30'd0, m_fwd(issue_rt)});
`ifdef HAZARD_STATS_EN
    check("stall_count", stall_count, m_count);
`endif
  endtask

  initial begin
    logic [4:0] ops [6];
    ops[0] = ALU_OP; ops[1] = ADDI_OP; ops[2] = LW_OP;
    ops[3] = SW_OP;  ops[4] = BEQ_OP;  ops[5] = J_OP;

    reset = 1'b1; issue_valid = 0; issue_opcode = 0;
    issue_rd = 0; issue_rs = 0; issue_rt = 0; flush = 0;
    repeat (2) @(posedge clock);

    // Reset state
    apply(1, ALU_OP, 5'd1, 5'd1, 5'd2, 0, 0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);

    // 1: add r3 then consumer of r3 -> EX forward
    apply(1, ALU_OP, 5'd3, 5'd9, 5'd10, 0, 0);
    apply(1, ALU_OP, 5'd8, 5'd3, 5'd0, 0, 0);
    check("t1_stall", {31'd0, stall}, 32'd0);
    check("t1_fwd_rs", {30'd0, fwd_rs}, 32'd1);
    check("t1_fwd_rt", {30'd0, fwd_rt}, 32'd0);

    // 2: lw r5 then consumer on rt -> one stall, then MEM forward
    apply(1, LW_OP, 5'd5, 5'd1, 5'd2, 0, 0);
    apply(1, ALU_OP, 5'd6, 5'd9, 5'd5, 0, 0);
    check("t2_stall", {31'd0, stall}, 32'd1);
    apply(1, ALU_OP, 5'd6, 5'd9, 5'd5, 0, 0);
    check("t2_stall_gone", {31'd0, stall}, 32'd0);
    check("t2_fwd_rt", {30'd0, fwd_rt}, 32'd2);

    // 3: addi r7, two unrelated, then rs=rt=r7 -> WB forward
    apply(1, ADDI_OP, 5'd7, 5'd0, 5'd0, 0, 0);
    apply(1, ALU_OP, 5'd11, 5'd12, 5'd13, 0, 0);
    apply(1, ALU_OP, 5'd14, 5'd15, 5'd16, 0, 0);
    apply(1, SW_OP, 5'd0, 5'd7, 5'd7, 0, 0);
    check("t3_fwd", {28'd0, fwd_rs, fwd_rt}, 32'hF);

    // 4: r0 never forwarded; EX beats MEM
    apply(1, ALU_OP, 5'd0, 5'd1, 5'd2, 0, 0);
    apply(1, ALU_OP, 5'd4, 5'd0, 5'd0, 0, 0);
    check("t4_r0", {29'd0, stall, fwd_rs}, 32'd0);
    apply(1, ALU_OP, 5'd4, 5'd1, 5'd1, 0, 0);
    apply(1, ALU_OP, 5'd9, 5'd4, 5'd4, 0, 0);
    check("t4_ex_wins", {28'd0, fwd_rs, fwd_rt}, 32'h5);

    // 5: flush with lw r2 in EX clears EX and MEM
    apply(1, LW_OP, 5'd2, 5'd1, 5'd1, 0, 0);
    apply(1, ALU_OP, 5'd9, 5'd2, 5'd2, 1, 0);
    apply(1, ALU_OP, 5'd9, 5'd2, 5'd2, 0, 0);
    check("t5_after_flush", {27'd0, stall, fwd_rs, fwd_rt}, 32'd0);

    // 6: reset mid-stream, then three load-use stalls
    apply(1, LW_OP, 5'd5, 5'd1, 5'd1, 0, 0);
    apply(0, ALU_OP, 5'd0, 5'd0, 5'd0, 0, 1);
    apply(1, ALU_OP, 5'd9, 5'd5, 5'd5, 0, 0);
    check("t6_after_reset", {27'd0, stall, fwd_rs, fwd_rt}, 32'd0);
`ifdef HAZARD_STATS_EN
    check("t6_count_reset", stall_count, 32'd0);
`endif
    for (int k = 0; k < 3; k++) begin
      apply(1, LW_OP, 5'd6, 5'd1, 5'd1, 0, 0);
      apply(1, ALU_OP, 5'd9, 5'd6, 5'd1, 0, 0);
      apply(1, ALU_OP, 5'd9, 5'd6, 5'd1, 0, 0);
    end
    apply(0, ALU_OP, 5'd0, 5'd0, 5'd0, 0, 0);
`ifdef HAZARD_STATS_EN
    check("t6_count_three", stall_count, 32'd3);
`endif

    // Random streams over a small register window so hazards are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic       v, fl, rs_t;
      logic [4:0] op, rd, rs, rt;
      v    = ($urandom_range(0, 9) != 0);
      op   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 5)];
      rd   = 5'($urandom_range(0, 7));
      rs   = 5'($urandom_range(0, 7));
      rt   = 5'($urandom_range(0, 7));
      fl   = ($urandom_range(0, 15) == 0);
      rs_t = ($urandom_range(0, 63) == 0);
      apply(v, op, rd, rs, rt, fl, rs_t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
